keycode_event_in: RTL and testbench
===================================

Name: keycode_event_in

Overview:
- Avalon-MM slave input port, the receive-direction counterpart of the CPU-written keycode output PIO.
- Captures keycode events from fabric logic (key scanner / keyboard decoder) into a small FIFO.
- The Nios CPU reads events through the register map and is interrupted on new data or overflow.
- Sits on the fpgaSynth system interconnect beside the existing PIOs.

Parameters:
DATA_W, 8, keycode width (max 23).
DEPTH, 8, FIFO entries; power of two, 2..64.
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, zero-latency (combinational from registers)
key_data  in  DATA_W  keycode from fabric producer
key_valid  in  1  one-cycle event strobe; producer never stalls
irq  out  1  level interrupt to CPU, registered

Behaviour:
- One clock domain. Reset is asynchronous and active-high and clears all state: FIFO empty, count=0, overflow=0, irq_mask=0, irq=0. readdata then returns the reset register contents (addr0 reads 0).
- Register map (rd = chipselect & ~read_n; wr = chipselect & ~write_n):
  - addr0 DATA (RO): {zeros, bit DATA_W = valid(~empty), [DATA_W-1:0] = head entry, 0 if empty}. A rd pops the head at the clock edge when not empty. A rd when empty has no effect.
  - addr1 STATUS: [CNT_W-1:0] = count, bit16 = empty, bit17 = full, bit18 = overflow. A wr with writedata[18]=1 clears overflow (W1C). Other bits are ignored.
  - addr2 IRQ_MASK (RW): bit0 = enable not-empty irq, bit1 = enable overflow irq; upper bits read 0.
  - addr3: reads 0; writes ignored.
- Push: on key_valid, if not full, write key_data at wr_ptr. wr_ptr increments mod DEPTH.
- Full: if key_valid while full, drop the event and set overflow. FIFO contents are unchanged.
- Simultaneous push and pop:
  - Non-empty and not full: both occur, count unchanged.
  - Empty: push only. The read returns valid=0.
  - Full: pop occurs and the push is dropped with overflow set. Full status comes from pre-edge state.
- Overflow:
  - Overflow set and W1C clear in the same cycle: set wins.
  - Overflow is sticky until cleared or reset.
- Pointers are log2(DEPTH) bits and wrap naturally. count tracks occupancy 0..DEPTH. empty = (count==0), full = (count==DEPTH).
- irq <= (mask[0] & ~empty_next) | (mask[1] & overflow_next), registered.
  - Rises the cycle after the qualifying push or mask write.
  - Drops the cycle after the pop that empties the FIFO, or after overflow is cleared.
- Read side effects apply only to addr0. Reads of other addresses are side-effect free.
- Reset mid-operation discards all queued events. The producer needs no notification.

Decomposition:
- Shared package keycode_pkg holds:
  - address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_IRQ_MASK=2;
  - STATUS bit positions EMPTY_BIT=16, FULL_BIT=17, OVF_BIT=18;
  - IRQ mask bit positions.
- One sub-module, keycode_fifo:
  - parameterised DATA_W/DEPTH synchronous FIFO with push, pop, head, count, empty, full;
  - register array with no reset needed; pointers and count reset.
- The top level holds the Avalon decode, overflow flag, mask and irq register.

Test Plan:
- Reset then read addr0 and addr1 -> readdata 0x0 and 0x00010000 (empty); irq=0.
- Push 0x1C, 0x1B, 0x23; read addr0 three times -> 0x11C, 0x11B, 0x123 in order; then addr1 = 0x00010000.
- Push 9 events with DEPTH=8 -> STATUS = 0x00060008 (full+overflow, count 8). The 9th value is never read back.
- Write addr2=0x1 and push one key -> irq=1 one cycle after push. Pop it -> irq=0 one cycle after pop.
- With full FIFO, push and pop in the same cycle -> count=7, overflow=1. Write addr1 0x00040000 -> overflow=0. With mask bit1 set, irq follows overflow.
- Assert reset with 5 entries queued -> count=0, empty=1, mask=0 immediately (async). Subsequent pushes start from a clean FIFO.

Source files
------------

// File: rtl/keycode_pkg.sv
// Shared constants for the keycode event input port: register addresses,
// STATUS bit positions and IRQ mask bit positions.
package keycode_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

    localparam int EMPTY_BIT = 16;
    localparam int FULL_BIT  = 17;
    localparam int OVF_BIT   = 18;

    localparam int IRQ_NE_BIT  = 0;
    localparam int IRQ_OVF_BIT = 1;

endpackage

// File: rtl/keycode_event_in_if.sv
// Avalon-MM slave bus bundle for the keycode event input port.
interface keycode_event_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/keycode_fifo.sv
// Small synchronous FIFO holding keycode events. Storage has no reset;
// pointers and occupancy count do. A push while full is refused even if a
// pop happens in the same cycle, so fullness is judged on pre-edge state.
module keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              empty_next
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign empty_next = (count_d == '0);

    // Next-state pointers and occupancy from the accepted push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/keycode_event_in.sv
// Avalon-MM keycode event input port: queues fabric keycode events in a
// FIFO, exposes DATA/STATUS/IRQ_MASK registers and drives a level irq.
module keycode_event_in
    import keycode_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    keycode_event_in_if.slave bus,
    input  logic [DATA_W-1:0] key_data,
    input  logic              key_valid,
    output logic              irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rd, wr;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              empty, full, empty_next;
    logic              overflow_q, overflow_d;
    logic [1:0]        mask_q, mask_d;
    logic              irq_q, irq_d;

    assign rd  = bus.chipselect & ~bus.read_n;
    assign wr  = bus.chipselect & ~bus.write_n;
    assign pop = rd & (bus.address == ADDR_DATA);
    assign irq = irq_q;

    keycode_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (key_valid),
        .pop        (pop),
        .din        (key_data),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .empty_next (empty_next)
    );

    // Overflow (set beats W1C clear), mask writes and next irq level.
    always_comb begin
        overflow_d = overflow_q;
        mask_d     = mask_q;
        if (wr && bus.address == ADDR_STATUS && bus.writedata[OVF_BIT])
            overflow_d = 1'b0;
        if (key_valid && full)
            overflow_d = 1'b1;
        if (wr && bus.address == ADDR_IRQ_MASK)
            mask_d = bus.writedata[1:0];
        irq_d = (mask_d[IRQ_NE_BIT] & ~empty_next) |
                (mask_d[IRQ_OVF_BIT] & overflow_d);
    end

    // Control registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            mask_q     <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    // Zero-latency read mux straight from current register state.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: begin
                if (!empty) begin
                    bus.readdata[DATA_W-1:0] = head;
                    bus.readdata[DATA_W]     = 1'b1;
                end
            end
            ADDR_STATUS: begin
                bus.readdata[CNT_W-1:0] = count;
                bus.readdata[EMPTY_BIT] = empty;
                bus.readdata[FULL_BIT]  = full;
                bus.readdata[OVF_BIT]   = overflow_q;
            end
            ADDR_IRQ_MASK: bus.readdata[1:0] = mask_q;
            default:       bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_keycode_event_in.sv
// Directed testbench for keycode_event_in (DATA_W=8, DEPTH=8).
module tb_keycode_event_in;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_data = '0;
    logic       key_valid = 1'b0;
    logic       irq;

    int checks = 0;
    int errors = 0;

    keycode_event_in_if bus ();

    keycode_event_in #(.DATA_W(8), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .key_data  (key_data),
        .key_valid (key_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        kv;
        logic [7:0]  kd;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_irq;
        logic        exp_irq;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic kv, logic [7:0] kd,
                                logic rd, logic wr, logic [1:0] addr,
                                logic [31:0] wd, logic chk_rd,
                                logic [31:0] exp_rd, logic chk_irq,
                                logic exp_irq);
        vec_t v;
        v.name = name; v.kv = kv; v.kd = kd; v.rd = rd; v.wr = wr;
        v.addr = addr; v.wd = wd; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.chk_irq = chk_irq; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle: readdata sampled before the edge, irq after it.
    task automatic apply(vec_t v);
        @(negedge clk);
        key_valid      = v.kv;
        key_data       = v.kd;
        bus.chipselect = v.rd | v.wr;
        bus.read_n     = ~v.rd;
        bus.write_n    = ~v.wr;
        bus.address    = v.addr;
        bus.writedata  = v.wd;
        #1;
        if (v.chk_rd) check({v.name, "_rd"}, bus.readdata, v.exp_rd);
        @(posedge clk);
        #1;
        if (v.chk_irq) check({v.name, "_irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
    endtask

    // Shorthands: push-only, read, write.
    function automatic vec_t pu(string n, logic [7:0] kd, logic ci, logic ei);
        return mk(n, 1'b1, kd, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, ci, ei);
    endfunction
    function automatic vec_t rdv(string n, logic [1:0] a, logic [31:0] e,
                                 logic ci, logic ei);
        return mk(n, 1'b0, 8'd0, 1'b1, 1'b0, a, 32'd0, 1'b1, e, ci, ei);
    endfunction
    function automatic vec_t wrv(string n, logic [1:0] a, logic [31:0] d,
                                 logic ci, logic ei);
        return mk(n, 1'b0, 8'd0, 1'b0, 1'b1, a, d, 1'b0, 32'd0, ci, ei);
    endfunction

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.read_n = 1'b1;
        bus.write_n = 1'b1; bus.writedata = '0;

        // Reset state and basic ordering
        vq.push_back(rdv("rst_data", 2'd0, 32'h0, 1'b1, 1'b0));
        vq.push_back(rdv("rst_status", 2'd1, 32'h0001_0000, 1'b1, 1'b0));
        vq.push_back(pu("push_1c", 8'h1C, 1'b1, 1'b0));
        vq.push_back(pu("push_1b", 8'h1B, 1'b0, 1'b0));
        vq.push_back(pu("push_23", 8'h23, 1'b0, 1'b0));
        vq.push_back(rdv("pop_1c", 2'd0, 32'h11C, 1'b0, 1'b0));
        vq.push_back(rdv("pop_1b", 2'd0, 32'h11B, 1'b0, 1'b0));
        vq.push_back(rdv("pop_23", 2'd0, 32'h123, 1'b0, 1'b0));
        vq.push_back(rdv("status_empty", 2'd1, 32'h0001_0000, 1'b0, 1'b0));
        vq.push_back(rdv("addr3", 2'd3, 32'h0, 1'b0, 1'b0));
        // Fill to full plus one overflowing push
        for (int i = 1; i <= 9; i++)
            vq.push_back(pu("fill", 8'(i), 1'b1, 1'b0));
        vq.push_back(rdv("status_full_ovf", 2'd1, 32'h0006_0008, 1'b0, 1'b0));
        // Full: pop and push together -> pop only, overflow stays
        vq.push_back(mk("full_pushpop", 1'b1, 8'hAA, 1'b1, 1'b0, 2'd0, 32'd0,
                        1'b1, 32'h101, 1'b1, 1'b0));
        vq.push_back(rdv("status_7_ovf", 2'd1, 32'h0004_0007, 1'b0, 1'b0));
        vq.push_back(wrv("w1c_ovf", 2'd1, 32'h0004_0000, 1'b0, 1'b0));
        vq.push_back(rdv("status_7", 2'd1, 32'h0000_0007, 1'b0, 1'b0));
        for (int i = 2; i <= 8; i++)
            vq.push_back(rdv("drain", 2'd0, 32'h100 | 32'(i), 1'b0, 1'b0));
        vq.push_back(rdv("empty_read", 2'd0, 32'h0, 1'b0, 1'b0));
        vq.push_back(rdv("status_drained", 2'd1, 32'h0001_0000, 1'b0, 1'b0));
        // Not-empty interrupt
        vq.push_back(wrv("mask_ne", 2'd2, 32'h1, 1'b1, 1'b0));
        vq.push_back(rdv("mask_rd", 2'd2, 32'h1, 1'b1, 1'b0));
        vq.push_back(pu("irq_push", 8'h55, 1'b1, 1'b1));
        vq.push_back(rdv("irq_pop", 2'd0, 32'h155, 1'b1, 1'b0));
        // Empty: push and pop together -> push only, read shows invalid
        vq.push_back(mk("empty_pushpop", 1'b1, 8'h66, 1'b1, 1'b0, 2'd0, 32'd0,
                        1'b1, 32'h0, 1'b1, 1'b1));
        vq.push_back(rdv("pop_66", 2'd0, 32'h166, 1'b1, 1'b0));
        // Non-empty: push and pop together -> count unchanged
        vq.push_back(pu("push_11", 8'h11, 1'b1, 1'b1));
        vq.push_back(mk("mid_pushpop", 1'b1, 8'h22, 1'b1, 1'b0, 2'd0, 32'd0,
                        1'b1, 32'h111, 1'b1, 1'b1));
        vq.push_back(rdv("status_1", 2'd1, 32'h0000_0001, 1'b1, 1'b1));
        vq.push_back(rdv("pop_22", 2'd0, 32'h122, 1'b1, 1'b0));
        // Overflow interrupt
        vq.push_back(wrv("mask_ovf", 2'd2, 32'h2, 1'b1, 1'b0));
        for (int i = 0; i < 8; i++)
            vq.push_back(pu("fill2", 8'h30 + 8'(i), 1'b1, 1'b0));
        vq.push_back(pu("ovf_push", 8'h38, 1'b1, 1'b1));
        vq.push_back(mk("ovf_set_wins", 1'b1, 8'h39, 1'b0, 1'b1, 2'd1,
                        32'h0004_0000, 1'b0, 32'd0, 1'b1, 1'b1));
        vq.push_back(rdv("status_set_wins", 2'd1, 32'h0006_0008, 1'b1, 1'b1));
        vq.push_back(wrv("ovf_clear", 2'd1, 32'h0004_0000, 1'b1, 1'b0));
        vq.push_back(rdv("status_cleared", 2'd1, 32'h0002_0008, 1'b1, 1'b0));
        vq.push_back(rdv("pop_30", 2'd0, 32'h130, 1'b1, 1'b0));
        vq.push_back(rdv("pop_31", 2'd0, 32'h131, 1'b1, 1'b0));
        vq.push_back(rdv("pop_32", 2'd0, 32'h132, 1'b1, 1'b0));
        vq.push_back(wrv("mask_both", 2'd2, 32'h3, 1'b1, 1'b1));
        vq.push_back(rdv("status_5", 2'd1, 32'h0000_0005, 1'b1, 1'b1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // Asynchronous reset mid-operation with 5 entries queued
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
        key_valid = 1'b0; bus.address = 2'd1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_status", bus.readdata, 32'h0001_0000);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        bus.address = 2'd2;
        #1;
        check("async_rst_mask", bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply(pu("post_rst_push", 8'h77, 1'b1, 1'b0));
        apply(rdv("post_rst_status", 2'd1, 32'h0000_0001, 1'b1, 1'b0));
        apply(rdv("post_rst_pop", 2'd0, 32'h177, 1'b1, 1'b0));
        apply(rdv("post_rst_empty", 2'd1, 32'h0001_0000, 1'b1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
